apmu_ibex_multdiv_arb: RTL

Shares the single EX-stage multiplier/divider between two requesters: port 0 is the core ID stage, port 1 is the APMU auxiliary compute port. It arbitrates, registers the winner's operands, and sequences the multi-cycle operation by driving mult/div enables and selects. It owns the 2x34-bit intermediate value register and returns the result to the owner. It sits between the ID stage, the APMU, and the EX block.

---
 rtl/apmu_ibex_pkg.sv | 35 +++
 rtl/apmu_ibex_multdiv_rr_sel.sv | 70 +++++++
 rtl/apmu_ibex_multdiv_arb.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/apmu_ibex_pkg.sv
// Shared types for the APMU / Ibex multiplier-divider sharing logic.
//   md_op_e      : multdiv operator (MUL low, MUL high, DIV, REM)
//   rv32m_e      : multdiv implementation flavour
//   arb_state_e  : state of the multdiv arbiter FSM
//   md_op_is_div : operator class helper (divider vs multiplier)
package apmu_ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    RV32MNone        = 2'd0,
    RV32MSlow        = 2'd1,
    RV32MFast        = 2'd2,
    RV32MSingleCycle = 2'd3
  } rv32m_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Starvation counter width; covers the legal Req1MaxWait range 1..255.
  localparam int unsigned WaitCntW = 8;

  function automatic logic md_op_is_div(md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/apmu_ibex_multdiv_rr_sel.sv
// Winner select with starvation protection for the two multdiv requesters.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   arb_en_i      : high in cycles where the arbiter may issue a grant
//   req_i[1:0]    : requests (0 = ID stage, 1 = APMU)
//   kill_i        : core flush, blocks a grant to requester 0
//   gnt_o[1:0]    : combinational one-hot winner
// Requester 0 normally wins. Each arbitration cycle in which requester 1 is
// refused bumps a saturating counter; once it reaches Req1MaxWait, requester 1
// wins the next arbitration and the counter clears.
module apmu_ibex_multdiv_rr_sel
  import apmu_ibex_pkg::*;
#(
  parameter int unsigned Req1MaxWait = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       arb_en_i,
  input  logic [1:0] req_i,
  input  logic       kill_i,
  output logic [1:0] gnt_o
);

  localparam logic [WaitCntW-1:0] MaxWait = WaitCntW'(Req1MaxWait);

  logic [WaitCntW-1:0] wait_cnt_d, wait_cnt_q;
  logic                starve_d, starve_q;
  logic                req0_ok;

  assign req0_ok = req_i[0] & ~kill_i;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o = 2'b00;
    if (arb_en_i) begin
      if (starve_q && req_i[1]) begin
        gnt_o = 2'b10;
      end else if (req0_ok) begin
        gnt_o = 2'b01;
      end else if (req_i[1]) begin
        gnt_o = 2'b10;
      end
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (arb_en_i && req_i[1]) begin
      if (gnt_o[1]) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q != MaxWait) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
    starve_d = (wait_cnt_d == MaxWait);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
      starve_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
    end
  end

endmodule

// File: rtl/apmu_ibex_multdiv_arb.sv
// Shares the EX-stage multiplier/divider between the ID stage (requester 0)
// and the APMU auxiliary compute port (requester 1).
//   req_i/op_i/signed_mode_i/op_a_i/op_b_i : per-requester request and operands
//   kill_i                : core flush, aborts requester-0 work only
//   gnt_o                 : one-hot grant (combinational, IDLE/RESP only)
//   rvalid_o/rdata_o      : one-cycle result pulse and data to the owner
//   mult_*/div_*, operator_o, signed_mode_o, operand_*_o : EX controls/operands
//   multdiv_ready_id_o    : release pulse to the multdiv
//   ex_valid_i/result_ex_i: EX result handshake
//   imd_val_*             : 2x34-bit intermediate value register owned here
module apmu_ibex_multdiv_arb
  import apmu_ibex_pkg::*;
#(
  parameter int unsigned Req1MaxWait = 8,
  parameter rv32m_e      RV32M       = RV32MFast
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [1:0]   req_i,
  input  md_op_e       op_i          [2],
  input  logic [1:0]   signed_mode_i [2],
  input  logic [31:0]  op_a_i        [2],
  input  logic [31:0]  op_b_i        [2],
  input  logic         kill_i,
  output logic [1:0]   gnt_o,
  output logic [1:0]   rvalid_o,
  output logic [31:0]  rdata_o,
  output logic         mult_en_o,
  output logic         div_en_o,
  output logic         mult_sel_o,
  output logic         div_sel_o,
  output md_op_e       operator_o,
  output logic [1:0]   signed_mode_o,
  output logic [31:0]  operand_a_o,
  output logic [31:0]  operand_b_o,
  output logic         multdiv_ready_id_o,
  input  logic         ex_valid_i,
  input  logic [31:0]  result_ex_i,
  input  logic [1:0]   imd_val_we_i,
  input  logic [33:0]  imd_val_d_i   [2],
  output logic [33:0]  imd_val_q_o   [2]
);

  localparam logic MdOn = (RV32M != RV32MNone);

  arb_state_e  state_d, state_q;
  logic        owner_d, owner_q;
  md_op_e      operator_d, operator_q;
  logic [1:0]  signed_mode_d, signed_mode_q;
  logic [31:0] operand_a_d, operand_a_q;
  logic [31:0] operand_b_d, operand_b_q;
  logic [31:0] rdata_d, rdata_q;
  logic [33:0] imd_val_d [2];
  logic [33:0] imd_val_q [2];

  logic arb_en, busy, kill_own0, abort, op_div, md_active, winner;

  // Reset also gates the grant so every output reads 0 while rst_ni is low,
  // even with requests held.
  assign arb_en    = MdOn & rst_ni & ((state_q == IDLE) | (state_q == RESP));
  assign busy      = MdOn & (state_q == BUSY);
  assign kill_own0 = kill_i & ~owner_q;
  assign abort     = busy & kill_own0;
  assign op_div    = md_op_is_div(operator_q);
  assign md_active = busy & ~abort;

  apmu_ibex_multdiv_rr_sel #(
    .Req1MaxWait (Req1MaxWait)
  ) u_rr_sel (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .arb_en_i (arb_en),
    .req_i    (req_i),
    .kill_i   (kill_i),
    .gnt_o    (gnt_o)
  );

  assign winner = gnt_o[1];

  assign mult_sel_o = md_active & ~op_div;
  assign div_sel_o  = md_active &  op_div;
  assign mult_en_o  = md_active & ~op_div;
  assign div_en_o   = md_active &  op_div;

  // A kill that aborts the op still releases the multdiv so it can restart.
  assign multdiv_ready_id_o = busy & (abort | ex_valid_i);

  assign rvalid_o = {owner_q, ~owner_q} & {2{(state_q == RESP) & ~kill_own0}};
  assign rdata_o  = (|rvalid_o) ? rdata_q : '0;

  assign operator_o    = operator_q;
  assign signed_mode_o = signed_mode_q;
  assign operand_a_o   = operand_a_q;
  assign operand_b_o   = operand_b_q;
  assign imd_val_q_o   = imd_val_q;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    operator_d    = operator_q;
    signed_mode_d = signed_mode_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    rdata_d       = rdata_q;
    imd_val_d     = imd_val_q;

    unique case (state_q)
      IDLE, RESP: begin
        if (|gnt_o) begin
          state_d       = BUSY;
          owner_d       = winner;
          operator_d    = op_i[winner];
          signed_mode_d = signed_mode_i[winner];
          operand_a_d   = op_a_i[winner];
          operand_b_d   = op_b_i[winner];
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ex_valid_i) begin
          state_d = RESP;
          rdata_d = result_ex_i;
        end
      end
      default: state_d = IDLE;
    endcase

    // The multdiv initialises these itself, so they are never cleared between ops.
    if (busy) begin
      for (int i = 0; i < 2; i++) begin
        if (imd_val_we_i[i]) imd_val_d[i] = imd_val_d_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      operator_q    <= MD_OP_MULL;
      signed_mode_q <= '0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      rdata_q       <= '0;
      // NOTE: the intermediate register is only two entries and drives ports
      // directly, so it is reset like any other flop rather than left as
      // uninitialised storage.
      for (int i = 0; i < 2; i++) imd_val_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      operator_q    <= operator_d;
      signed_mode_q <= signed_mode_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      rdata_q       <= rdata_d;
      imd_val_q     <= imd_val_d;
    end
  end

endmodule
